// File: rtl/trunnion_drive_responder.sv
// Optics trunnion servo responder: accumulates AGC CDU drive pulses into a signed
// error count and pays it back as paced TRNP/TRNM pulses. Define TRNDRV_ANGLE_EN for the angle counter.
module trunnion_drive_responder #(
   parameter int ERR_W   = 12,
   parameter int ANGLE_W = 16,
   parameter int PULSE_W = 8,
   parameter int GAP_W   = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cduclk,
   input  logic                      drive_p,
   input  logic                      drive_m,
   input  logic                      zop,
   output logic                      pulse_p,
   output logic                      pulse_m,
   output logic signed [ERR_W-1:0]   err,
   output logic        [ANGLE_W-1:0] angle,
   output logic                      busy
);

   localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SUM_W   = ERR_W + 2;

   localparam logic signed [SUM_W-1:0] SUM_ONE  = 1;
   localparam logic signed [SUM_W-1:0] SUM_MONE = -1;
   localparam logic signed [SUM_W-1:0] SUM_ZERO = 0;
   localparam logic signed [SUM_W-1:0] ERR_MAX  = (2 ** (ERR_W - 1)) - 1;
   localparam logic signed [SUM_W-1:0] ERR_MIN  = -((2 ** (ERR_W - 1)) - 1);
   localparam logic [CNT_W-1:0]        PULSE_LD = CNT_W'(PULSE_W - 1);
   localparam logic [CNT_W-1:0]        GAP_LD   = CNT_W'(GAP_W - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   logic [1:0]               r_cduSync;
   logic [1:0]               r_dpSync;
   logic [1:0]               r_dmSync;
   logic [1:0]               r_zopSync;
   logic                     r_cduPrev;
   state_t                   r_state;
   state_t                   w_nextState;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_nextCnt;
   logic                     r_dirP;
   logic signed [ERR_W-1:0]  r_err;
   logic signed [ERR_W-1:0]  w_errNext;
   logic signed [SUM_W-1:0]  w_errExt;
   logic signed [SUM_W-1:0]  w_deltaExt;
   logic signed [SUM_W-1:0]  w_issueExt;
   logic signed [SUM_W-1:0]  w_errSum;
   logic                     w_cduRise;
   logic                     w_zop;
   logic                     w_issue;
   logic                     w_errPos;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cduSync <= '0;
         r_dpSync  <= '0;
         r_dmSync  <= '0;
         r_zopSync <= '0;
         r_cduPrev <= 1'b0;
      end else begin
         r_cduSync <= {r_cduSync[0], cduclk};
         r_dpSync  <= {r_dpSync[0], drive_p};
         r_dmSync  <= {r_dmSync[0], drive_m};
         r_zopSync <= {r_zopSync[0], zop};
         r_cduPrev <= r_cduSync[1];
      end
   end

   assign w_cduRise = r_cduSync[1] & ~r_cduPrev;
   assign w_zop     = r_zopSync[1];
   assign w_errPos  = ~r_err[ERR_W-1];

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_issue     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if ((r_err != '0) && !w_zop) begin
               w_nextState = PULSE;
               w_nextCnt   = PULSE_LD;
               w_issue     = 1'b1;
            end
         end
         PULSE: begin
            if (r_cnt == '0) begin
               w_nextState = GAP;
               w_nextCnt   = GAP_LD;
            end else begin
               w_nextCnt = r_cnt - CNT_W'(1);
            end
         end
         GAP: begin
            if (r_cnt == '0) begin
               w_nextState = IDLE;
            end else begin
               w_nextCnt = r_cnt - CNT_W'(1);
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Drive delta and the issued pulse fold into one saturating update, so a
   // simultaneous +1 drive and +1 issue leave the count unchanged.
   always_comb begin
      w_errExt   = {{2{r_err[ERR_W-1]}}, r_err};
      w_deltaExt = SUM_ZERO;
      w_issueExt = SUM_ZERO;
      if (w_cduRise && r_dpSync[1] && !r_dmSync[1]) begin
         w_deltaExt = SUM_ONE;
      end else if (w_cduRise && !r_dpSync[1] && r_dmSync[1]) begin
         w_deltaExt = SUM_MONE;
      end
      if (w_issue) begin
         w_issueExt = w_errPos ? SUM_ONE : SUM_MONE;
      end
      w_errSum = w_errExt + w_deltaExt - w_issueExt;
      if (w_zop) begin
         w_errNext = '0;
      end else if (w_errSum > ERR_MAX) begin
         w_errNext = ERR_MAX[ERR_W-1:0];
      end else if (w_errSum < ERR_MIN) begin
         w_errNext = ERR_MIN[ERR_W-1:0];
      end else begin
         w_errNext = w_errSum[ERR_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_dirP  <= 1'b0;
         r_err   <= '0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_err   <= w_errNext;
         if (w_issue) begin
            r_dirP <= w_errPos;
         end
      end
   end

`ifdef TRNDRV_ANGLE_EN
   logic [ANGLE_W-1:0] r_angle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_angle <= '0;
      end else if (w_issue) begin
         r_angle <= w_errPos ? (r_angle + ANGLE_W'(1)) : (r_angle - ANGLE_W'(1));
      end
   end

   assign angle = r_angle;
`else
   assign angle = '0;
`endif

   // Direction is latched at pulse entry, so a sign flip mid-pulse cannot swap outputs.
   assign pulse_p = (r_state == PULSE) &  r_dirP;
   assign pulse_m = (r_state == PULSE) & ~r_dirP;
   assign busy    = (r_state != IDLE);
   assign err     = r_err;

endmodule

// File: tb/tb_trunnion_drive_responder.sv
// Scoreboard bench for trunnion_drive_responder: stimulus pushes expected feedback
// pulses, a negedge monitor pops and checks each pulse as it appears.
module tb_trunnion_drive_responder;

   localparam int ERR_W   = 12;
   localparam int ANGLE_W = 16;
   localparam int PULSE_W = 8;
   localparam int GAP_W   = 64;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic cduclk  = 1'b0;
   logic drive_p = 1'b0;
   logic drive_m = 1'b0;
   logic zop     = 1'b0;
   logic                      pulse_p;
   logic                      pulse_m;
   logic                      busy;
   logic signed [ERR_W-1:0]   err;
   logic        [ANGLE_W-1:0] angle;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit dirP;
      int angleAfter;
   } expPulse_t;

   expPulse_t expQ[$];
   expPulse_t monE;
   int        angleModel = 0;

   bit satPhase = 1'b0;
   int satMax   = 0;
   bit satNeg   = 1'b0;
   bit satM     = 1'b0;

   bit prevActive = 1'b0;
   bit seenPulse  = 1'b0;
   int highCnt    = 0;
   int lowCnt     = 0;

   always #5 clk = ~clk;

   trunnion_drive_responder #(
      .ERR_W  (ERR_W),
      .ANGLE_W(ANGLE_W),
      .PULSE_W(PULSE_W),
      .GAP_W  (GAP_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .cduclk (cduclk),
      .drive_p(drive_p),
      .drive_m(drive_m),
      .zop    (zop),
      .pulse_p(pulse_p),
      .pulse_m(pulse_m),
      .err    (err),
      .angle  (angle),
      .busy   (busy)
   );

   // Angle reads back as zero when the counter is compiled out.
   function automatic int expAngle(input int a);
`ifdef TRNDRV_ANGLE_EN
      return ((a % 65536) + 65536) % 65536;
`else
      return 0 * a;
`endif
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One CDUCLK rise with the drive lines held, then a quiet low period.
   task automatic applyStimulus(input bit dp, input bit dm, input int spacing);
      @(negedge clk);
      drive_p = dp;
      drive_m = dm;
      cduclk  = 1'b1;
      repeat (2) @(negedge clk);
      cduclk = 1'b0;
      repeat (spacing - 2) @(negedge clk);
   endtask

   task automatic runBurst(input bit dp, input bit dm, input int n, input int spacing);
      for (int i = 0; i < n; i++) begin
         if (dp ^ dm) begin
            angleModel += dp ? 1 : -1;
            expQ.push_back('{dirP: dp, angleAfter: angleModel});
         end
         applyStimulus(dp, dm, spacing);
      end
      drive_p = 1'b0;
      drive_m = 1'b0;
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      angleModel = 0;
      expQ.delete();
      rst = 1'b0;
   endtask

   task automatic waitDrain(input string tag, input int budget);
      int cycles;
      cycles = 0;
      repeat (5) @(negedge clk);
      while ((busy || err != '0) && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      if (cycles >= budget) checkOutput({tag, "DrainTimeout"}, 1, 0);
      checkOutput({tag, "Err"}, int'(err), 0);
      checkOutput({tag, "Busy"}, int'(busy), 0);
      checkOutput({tag, "Angle"}, int'(angle), expAngle(angleModel));
      checkOutput({tag, "QueueLeft"}, expQ.size(), 0);
   endtask

   // Monitor: pulse shape, spacing, exclusivity and scoreboard pop on each rise.
   always @(negedge clk) begin
      if (rst) begin
         prevActive = 1'b0;
         seenPulse  = 1'b0;
         highCnt    = 0;
         lowCnt     = 0;
      end else begin
         if (pulse_p && pulse_m) checkOutput("pulseExclusive", 1, 0);
         if (satPhase) begin
            if (int'(err) > satMax) satMax = int'(err);
            if (int'(err) < 0) satNeg = 1'b1;
            if (pulse_m) satM = 1'b1;
         end
         if ((pulse_p || pulse_m) && !prevActive) begin
            if (seenPulse) checkOutput("gapMinLow", int'(lowCnt >= GAP_W), 1);
            seenPulse = 1'b1;
            highCnt   = 1;
            if (!satPhase) begin
               if (expQ.size() == 0) begin
                  checkOutput("unexpectedPulse", 1, 0);
               end else begin
                  monE = expQ.pop_front();
                  checkOutput("pulseDir", int'(pulse_p), int'(monE.dirP));
                  checkOutput("pulseAngle", int'(angle), expAngle(monE.angleAfter));
               end
            end
         end else if (pulse_p || pulse_m) begin
            highCnt++;
         end else if (prevActive) begin
            checkOutput("pulseWidth", highCnt, PULSE_W);
            lowCnt = 1;
         end else begin
            lowCnt++;
         end
         prevActive = pulse_p || pulse_m;
      end
   end

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sel;
      int n;
      int spacing;
      bit dp;
      bit dm;

      // Reset held while the AGC keeps driving.
      drive_p = 1'b1;
      for (int i = 0; i < 3; i++) begin
         repeat (2) @(negedge clk);
         cduclk = ~cduclk;
         @(negedge clk);
         checkOutput("rstPulseP", int'(pulse_p), 0);
         checkOutput("rstPulseM", int'(pulse_m), 0);
         checkOutput("rstErr", int'(err), 0);
         checkOutput("rstAngle", int'(angle), 0);
         checkOutput("rstBusy", int'(busy), 0);
      end
      cduclk  = 1'b0;
      drive_p = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("postRstErr", int'(err), 0);

      $display("[TB] positive step");
      runBurst(1'b1, 1'b0, 5, 6);
      waitDrain("posStep", 5 * 80 + 200);

      $display("[TB] negative wrap");
      applyReset();
      runBurst(1'b0, 1'b1, 3, 6);
      waitDrain("negWrap", 3 * 80 + 200);
`ifdef TRNDRV_ANGLE_EN
      checkOutput("negWrapRaw", int'(angle), 32'h0000_FFFD);
`else
      checkOutput("negWrapRaw", int'(angle), 0);
`endif

      $display("[TB] conflicting drive");
      runBurst(1'b1, 1'b1, 3, 6);
      repeat (20) @(negedge clk);
      checkOutput("conflictErr", int'(err), 0);
      checkOutput("conflictBusy", int'(busy), 0);

      $display("[TB] random bursts");
      for (int b = 0; b < 15; b++) begin
         sel     = $urandom_range(0, 3);
         n       = $urandom_range(1, 6);
         spacing = $urandom_range(4, 12);
         dp      = (sel == 0) || (sel == 2);
         dm      = (sel == 1) || (sel == 2);
         runBurst(dp, dm, n, spacing);
         waitDrain("rand", n * 80 + 200);
      end

      // Ten quick rises: only the first pulse fits before zop lands in its gap.
      $display("[TB] zop during gap");
      applyReset();
      angleModel = 1;
      expQ.push_back('{dirP: 1'b1, angleAfter: 1});
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 4);
      drive_p = 1'b0;
      checkOutput("zopPreErr", int'(err), 9);
      checkOutput("zopInGapBusy", int'(busy), 1);
      checkOutput("zopInGapPulse", int'(pulse_p), 0);
      zop = 1'b1;
      repeat (80) @(negedge clk);
      checkOutput("zopErr", int'(err), 0);
      checkOutput("zopBusy", int'(busy), 0);
      applyStimulus(1'b1, 1'b0, 6);
      applyStimulus(1'b1, 1'b0, 6);
      drive_p = 1'b0;
      checkOutput("zopHeldErr", int'(err), 0);
      zop = 1'b0;
      repeat (100) @(negedge clk);
      checkOutput("zopRelErr", int'(err), 0);
      checkOutput("zopRelBusy", int'(busy), 0);
      checkOutput("zopAngle", int'(angle), expAngle(angleModel));
      checkOutput("zopQueueLeft", expQ.size(), 0);

      $display("[TB] saturation");
      applyReset();
      satMax   = 0;
      satNeg   = 1'b0;
      satM     = 1'b0;
      satPhase = 1'b1;
      for (int i = 0; i < 3000; i++) applyStimulus(1'b1, 1'b0, 4);
      drive_p = 1'b0;
      @(negedge clk);
      checkOutput("satMax", satMax, 2047);
      checkOutput("satNeverNeg", int'(satNeg), 0);
      checkOutput("satNoPulseM", int'(satM), 0);
      checkOutput("satHeld", int'(int'(err) >= 2040), 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      satPhase = 1'b0;
      applyReset();
      repeat (3) @(negedge clk);
      checkOutput("finalErr", int'(err), 0);
      checkOutput("finalAngle", int'(angle), 0);
      checkOutput("finalBusy", int'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
